// File: rtl/i2s_sck_ws_gen.sv
// i2s_sck_ws_gen: I2S bit-clock/word-select sequencer; master divides aud_clk_i,
// slave synchronises external SCK/WS, both emit drive/sample strobes and slot markers.
module i2s_sck_ws_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 aud_clk_i,
  input  logic                 aud_rst_n_i,
  input  logic                 en_i,
  input  logic                 msr_i,
  input  logic                 pol_i,
  input  logic                 chl_i,
  input  logic [1:0]           fmt_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 sck_i,
  input  logic                 ws_i,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sck_en_o,
  output logic                 ws_en_o,
  output logic                 tx_shift_o,
  output logic                 rx_sample_o,
  output logic                 slot_start_o,
  output logic                 frame_start_o,
  output logic                 ch_o,
  output logic [CNT_WIDTH-1:0] bit_cnt_o,
  output logic                 busy_o
);
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [CNT_WIDTH-1:0] last, bit_nxt;
  logic [1:0] sck_sync, ws_sync;
  logic phase, s_prev, ws_smp, pend, pend_ch;
  logic toggle, s, s_rise, s_fall, wrap, ws_flip;
  assign last    = chl_i ? CNT_WIDTH'(31) : CNT_WIDTH'(15);
  assign wrap    = bit_cnt_o == last;
  assign bit_nxt = wrap ? '0 : bit_cnt_o + CNT_WIDTH'(1);
  // MSB/LSB justified flip WS at the slot wrap; I2S (and reserved 11) one bit early
  assign ws_flip = (fmt_i[0] ^ fmt_i[1]) ? wrap : bit_nxt == last;
  assign toggle  = div_cnt >= div_i;
  assign s       = sck_sync[1] ^ pol_i;
  assign s_rise  = s & ~s_prev;
  assign s_fall  = ~s & s_prev;
  always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
    if (!aud_rst_n_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      s_prev   <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck_i};
      ws_sync  <= {ws_sync[0], ws_i};
      s_prev   <= s;
    end
  end
  always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
    if (!aud_rst_n_i) begin
      div_cnt       <= '0;
      phase         <= 1'b0;
      ws_smp        <= 1'b0;
      pend          <= 1'b0;
      pend_ch       <= 1'b0;
      sck_o         <= 1'b0;
      ws_o          <= 1'b0;
      sck_en_o      <= 1'b0;
      ws_en_o       <= 1'b0;
      tx_shift_o    <= 1'b0;
      rx_sample_o   <= 1'b0;
      slot_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      ch_o          <= 1'b0;
      bit_cnt_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      tx_shift_o    <= 1'b0;
      rx_sample_o   <= 1'b0;
      slot_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      sck_en_o      <= en_i & msr_i;
      ws_en_o       <= en_i & msr_i;
      if (!en_i) begin
        div_cnt   <= '0;
        phase     <= 1'b0;
        bit_cnt_o <= '0;
        sck_o     <= pol_i;
        ws_o      <= 1'b0;
        ch_o      <= 1'b0;
        busy_o    <= 1'b0;
        pend      <= 1'b0;
      end else if (msr_i) begin
        if (!busy_o) begin
          busy_o        <= 1'b1;
          div_cnt       <= '0;
          phase         <= 1'b0;
          bit_cnt_o     <= '0;
          sck_o         <= pol_i;
          ws_o          <= 1'b0;
          ch_o          <= 1'b0;
          tx_shift_o    <= 1'b1;
          slot_start_o  <= 1'b1;
          frame_start_o <= 1'b1;
        end else if (toggle) begin
          div_cnt     <= '0;
          phase       <= ~phase;
          sck_o       <= ~phase ^ pol_i;
          rx_sample_o <= ~phase;
          tx_shift_o  <= phase;
          if (phase) begin
            bit_cnt_o <= bit_nxt;
            if (ws_flip) ws_o <= ~ws_o;
            if (wrap) begin
              ch_o          <= ~ch_o;
              slot_start_o  <= 1'b1;
              frame_start_o <= ch_o;
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
      end else begin
        div_cnt <= '0;
        phase   <= 1'b0;
        sck_o   <= pol_i;
        ws_o    <= 1'b0;
        if (s_rise) begin
          ws_smp      <= ws_sync[1];
          rx_sample_o <= busy_o;
          if (ws_sync[1] != ws_smp) begin
            pend    <= 1'b1;
            pend_ch <= ws_sync[1];
          end
        end
        // a WS change seen on a sample edge opens the next slot one drive edge later
        if (s_fall) begin
          if (pend) begin
            pend          <= 1'b0;
            busy_o        <= 1'b1;
            ch_o          <= pend_ch;
            bit_cnt_o     <= '0;
            tx_shift_o    <= 1'b1;
            slot_start_o  <= 1'b1;
            frame_start_o <= ~pend_ch;
          end else if (busy_o) begin
            tx_shift_o <= 1'b1;
            if (!wrap) bit_cnt_o <= bit_nxt;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_sck_ws_gen.sv
// tb_i2s_sck_ws_gen: scoreboard bench; expected strobe events are queued as stimulus
// is applied and matched against each tx/rx strobe the DUT emits.
module tb_i2s_sck_ws_gen;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_i = 0, msr_i = 0, pol_i = 1, chl_i = 0, sck_i = 0, ws_i = 0;
  logic [1:0] fmt_i = 0;
  logic [15:0] div_i = 0;
  logic sck_o, ws_o, sck_en_o, ws_en_o, tx_shift_o, rx_sample_o;
  logic slot_start_o, frame_start_o, ch_o, busy_o;
  logic [4:0] bit_cnt_o;
  int cyc = 0, checks = 0, failures = 0;
  logic mon_on = 0;
  typedef struct {int cyc; logic [11:0] vec;} ev_t;
  ev_t exp_q[$];

  i2s_sck_ws_gen dut (
    .aud_clk_i(clk), .aud_rst_n_i(rst_n), .en_i(en_i), .msr_i(msr_i), .pol_i(pol_i),
    .chl_i(chl_i), .fmt_i(fmt_i), .div_i(div_i), .sck_i(sck_i), .ws_i(ws_i),
    .sck_o(sck_o), .ws_o(ws_o), .sck_en_o(sck_en_o), .ws_en_o(ws_en_o),
    .tx_shift_o(tx_shift_o), .rx_sample_o(rx_sample_o), .slot_start_o(slot_start_o),
    .frame_start_o(frame_start_o), .ch_o(ch_o), .bit_cnt_o(bit_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [11:0] v);
    ev_t ev;
    ev.cyc = c;
    ev.vec = v;
    exp_q.push_back(ev);
  endtask

  function automatic logic [11:0] mk(input logic tx, rx, sl, fr, ch, ws, sck, input int b);
    return {tx, rx, sl, fr, ch, ws, sck, 5'(b)};
  endfunction

  function automatic logic exp_ws(input int k, input int n, input logic [1:0] f);
    return (f == 2'b01 || f == 2'b10) ? 1'((k / n) % 2) : 1'(((k + 1) / n) % 2);
  endfunction

  function automatic logic [14:0] all_out();
    return {sck_o, ws_o, sck_en_o, ws_en_o, tx_shift_o, rx_sample_o, slot_start_o,
            frame_start_o, ch_o, busy_o, bit_cnt_o};
  endfunction

  always @(negedge clk) begin
    if (mon_on && (tx_shift_o || rx_sample_o)) begin
      check("tx_rx_excl", 32'(tx_shift_o & rx_sample_o), 0);
      if (exp_q.size() == 0) check("extra_strobe", cyc, 0);
      else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("strobe_cyc", cyc, ev.cyc);
        check("strobe_vec", 32'({tx_shift_o, rx_sample_o, slot_start_o, frame_start_o,
                                 ch_o, ws_o, sck_o, bit_cnt_o}), 32'(ev.vec));
      end
    end
  end

  task automatic run_master(input int d, input logic chl, input logic [1:0] f,
                            input logic p, input int kn);
    int n, h, e;
    n = chl ? 32 : 16;
    h = d + 1;
    div_i = 16'(d); chl_i = chl; fmt_i = f; pol_i = p; msr_i = 1;
    tick(1);
    en_i = 1;
    e = cyc + 1;
    for (int k = 0; k < kn; k++) begin
      push(e + 2*h*k, mk(1, 0, k % n == 0, k % (2*n) == 0, 1'((k / n) % 2), exp_ws(k, n, f), p, k % n));
      push(e + h + 2*h*k, mk(0, 1, 0, 0, 1'((k / n) % 2), exp_ws(k, n, f), ~p, k % n));
    end
    mon_on = 1;
    tick(e + 2*h*kn - 1 - cyc);
    @(negedge clk); #1;
    check("end_bit", 32'(bit_cnt_o), (kn - 1) % n);
    check("end_ch", 32'(ch_o), ((kn - 1) / n) % 2);
    check("end_busy", 32'(busy_o), 1);
    check("end_sck_en", 32'(sck_en_o), 1);
    check("leftover", exp_q.size(), 0);
    exp_q.delete();
    mon_on = 0;
    en_i = 0;
    tick(1);
    check("dis_sck", 32'(sck_o), 32'(p));
    check("dis_ws", 32'(ws_o), 0);
    check("dis_busy", 32'(busy_o), 0);
    check("dis_bit", 32'(bit_cnt_o), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e, m, bexp, j0;
    logic sch;
    tick(3);
    check("reset_outputs", 32'(all_out()), 0);
    rst_n = 1;
    tick(1);
    check("idle_sck_pol", 32'(sck_o), 1);
    check("idle_busy", 32'(busy_o), 0);
    run_master(1, 0, 2'b00, 0, 24);
    run_master(0, 1, 2'b01, 0, 68);
    run_master(1, 0, 2'b00, 1, 20);
    run_master(2, 0, 2'b10, 0, 20);
    run_master(1, 0, 2'b11, 0, 18);
    div_i = 7; chl_i = 0; fmt_i = 0; pol_i = 0; msr_i = 1;
    en_i = 1;
    e = cyc + 1;
    push(e,      mk(1, 0, 1, 1, 0, 0, 0, 0));
    push(e + 6,  mk(0, 1, 0, 0, 0, 0, 1, 0));
    push(e + 9,  mk(1, 0, 0, 0, 0, 0, 0, 1));
    push(e + 12, mk(0, 1, 0, 0, 0, 0, 1, 1));
    push(e + 15, mk(1, 0, 0, 0, 0, 0, 0, 2));
    push(e + 18, mk(0, 1, 0, 0, 0, 0, 1, 2));
    mon_on = 1;
    tick(e + 5 - cyc);
    div_i = 2;
    tick(e + 19 - cyc);
    mon_on = 0;
    check("div_leftover", exp_q.size(), 0);
    exp_q.delete();
    #2 rst_n = 0;
    #1 check("async_reset", 32'(all_out()), 0);
    en_i = 0;
    tick(2);
    rst_n = 1;
    tick(1);
    j0 = 3;
    msr_i = 0; pol_i = 0; chl_i = 0; sck_i = 0; ws_i = 0; en_i = 1;
    tick(3);
    check("slv_sck_en", 32'(sck_en_o), 0);
    check("slv_ws_en", 32'(ws_en_o), 0);
    check("slv_pre_busy", 32'(busy_o), 0);
    mon_on = 1;
    for (int j = 0; j < j0 + 38; j++) begin
      m = j - j0 - 1;
      sch = m < 16;
      bexp = m < 16 ? m : (m - 16 > 15 ? 15 : m - 16);
      sck_i = 0;
      if (j == j0 || j == j0 + 16) ws_i = ~ws_i;
      if (m >= 0) push(cyc + 3, mk(1, 0, m == 0 || m == 16, m == 16, sch, 0, 0, bexp));
      tick(4);
      if (j == j0) check("slv_idle_busy", 32'(busy_o), 0);
      sck_i = 1;
      if (m >= 0) push(cyc + 3, mk(0, 1, 0, 0, sch, 0, 0, bexp));
      tick(4);
    end
    mon_on = 0;
    check("slv_leftover", exp_q.size(), 0);
    check("slv_sat_bit", 32'(bit_cnt_o), 15);
    check("slv_ch", 32'(ch_o), 0);
    check("slv_busy", 32'(busy_o), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
